// File: rtl/lwc_host_pkg.sv
// ============================================================================
// lwc_host_pkg : shared constants and helpers for the host-side DO sink
// Rev 1.0
// ============================================================================
`default_nettype none

package lwc_host_pkg;

    localparam int HDR_TYPE_MSB = 31;
    localparam int HDR_LEN_W    = 16;

    localparam logic [3:0] STAT_SUCCESS = 4'hE;
    localparam logic [3:0] STAT_FAILURE = 4'hF;

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    // Byte length rounded up to whole 32-bit words; 0xFFFF still fits in 15 bits.
    function automatic logic [14:0] hdr_words(input logic [HDR_LEN_W-1:0] len);
        logic [HDR_LEN_W:0] sum;
        sum = {1'b0, len} + 17'd3;
        return sum[HDR_LEN_W:2];
    endfunction

    function automatic logic is_status(input logic [3:0] typ);
        return (typ == STAT_SUCCESS) || (typ == STAT_FAILURE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lwc_sync_fifo.sv
// ============================================================================
// lwc_sync_fifo : single-clock first-word fall-through FIFO with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module lwc_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head is forced to zero when empty so stale storage never leaks out.
    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lwc_do_sink.sv
// ============================================================================
// lwc_do_sink : host receiver for the LWC DO stream; parses headers, buffers
//               payload words and reports the trailing status word
// Rev 1.0
// ============================================================================
`default_nettype none

module lwc_do_sink
    import lwc_host_pkg::*;
#(
    parameter int BUSW       = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [BUSW-1:0] do_data,
    input  logic            do_valid,
    input  logic            do_last,
    output logic            do_ready,
    output logic [BUSW-1:0] out_data,
    output logic            out_seg_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            done,
    output logic            pass,
    output logic            proto_err,
    output logic [7:0]      seg_cnt
);

    logic [0:0]  state_q, state_d;
    logic [14:0] wcnt_q,  wcnt_d;
    logic        done_q,  done_d;
    logic        pass_q,  pass_d;
    logic        perr_q,  perr_d;
    logic [7:0]  seg_q,   seg_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic [BUSW:0]   fifo_dout;
    logic            accept;
    logic [3:0]      w_type;
    logic [14:0]     w_words;

    // Ready depends only on state and FIFO level; held low throughout reset.
    assign do_ready  = rst && ((state_q == S_HDR) ? 1'b1 : !fifo_full);
    assign accept    = do_valid && do_ready && !clear;
    assign fifo_push = accept && (state_q == S_DATA);

    assign w_type  = do_data[HDR_TYPE_MSB -: 4];
    assign w_words = hdr_words(do_data[HDR_LEN_W-1:0]);

    lwc_sync_fifo #(
        .WIDTH (BUSW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (clear),
        .push_i  (fifo_push),
        .din_i   ({(wcnt_q == 15'd1), do_data}),
        .pop_i   (out_ready),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        perr_d  = perr_q;
        seg_d   = seg_q;

        if (clear) begin
            state_d = S_HDR;
            wcnt_d  = '0;
            pass_d  = 1'b0;
            perr_d  = 1'b0;
            seg_d   = '0;
        end else if (accept) begin
            if (state_q == S_HDR) begin
                if (is_status(w_type)) begin
                    done_d = 1'b1;
                    pass_d = (w_type == STAT_SUCCESS);
                    if (!do_last) begin
                        perr_d = 1'b1;
                    end
                end else begin
                    // A header flagged last is still a header; it is counted and parsed.
                    seg_d = seg_q + 8'd1;
                    if (do_last) begin
                        perr_d = 1'b1;
                    end
                    if (w_words != '0) begin
                        wcnt_d  = w_words;
                        state_d = S_DATA;
                    end
                end
            end else begin
                wcnt_d = wcnt_q - 15'd1;
                if (do_last) begin
                    perr_d = 1'b1;
                end
                if ((wcnt_q == 15'd1) || do_last) begin
                    state_d = S_HDR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            perr_q  <= 1'b0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            perr_q  <= perr_d;
            seg_q   <= seg_d;
        end
    end

    assign out_data     = fifo_dout[BUSW-1:0];
    assign out_seg_last = fifo_dout[BUSW];
    assign out_valid    = !fifo_empty;
    assign done         = done_q;
    assign pass         = pass_q;
    assign proto_err    = perr_q;
    assign seg_cnt      = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_lwc_do_sink.sv
// ============================================================================
// tb_lwc_do_sink : directed, table-driven bench for lwc_do_sink
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lwc_do_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] do_data = '0;
    logic        do_valid = 1'b0;
    logic        do_last = 1'b0;
    logic        do_ready;
    logic [31:0] out_data;
    logic        out_seg_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        done;
    logic        pass;
    logic        proto_err;
    logic [7:0]  seg_cnt;

    int checks = 0;
    int errors = 0;

    lwc_do_sink #(.BUSW(32), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .do_data      (do_data),
        .do_valid     (do_valid),
        .do_last      (do_last),
        .do_ready     (do_ready),
        .out_data     (out_data),
        .out_seg_last (out_seg_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .done         (done),
        .pass         (pass),
        .proto_err    (proto_err),
        .seg_cnt      (seg_cnt)
    );

    always #5 clk = ~clk;

    // pop=1: expect head {data,last}; pop=0: send {data,last}, then check flags.
    typedef struct {
        bit          pop;
        logic [31:0] data;
        logic        last;
        logic        exp_done;
        logic        exp_pass;
        logic [7:0]  exp_seg;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        @(negedge clk);
        do_data  = d;
        do_last  = l;
        do_valid = 1'b1;
        n = 0;
        while (!do_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!do_ready) begin
            chk("send_timeout", 64'd1, 64'd0);
            do_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        do_valid = 1'b0;
        do_last  = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [31:0] d, input logic l);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({name, "_timeout"}, 64'd1, 64'd0);
            return;
        end
        chk({name, "_data"}, 64'(out_data), 64'(d));
        chk({name, "_seglast"}, 64'(out_seg_last), 64'(l));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].pop) begin
                pop_check($sformatf("vec%0d_pop", i), vecs[i].data, vecs[i].last);
            end else begin
                send(vecs[i].data, vecs[i].last);
                chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
                chk($sformatf("vec%0d_pass", i), 64'(pass), 64'(vecs[i].exp_pass));
                chk($sformatf("vec%0d_seg", i), 64'(seg_cnt), 64'(vecs[i].exp_seg));
                chk($sformatf("vec%0d_err", i), 64'(proto_err), 64'(vecs[i].exp_err));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_do_ready"}, 64'(do_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_seg_last"}, 64'(out_seg_last), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_err"}, 64'(proto_err), 64'd0);
        chk({tag, "_seg"}, 64'(seg_cnt), 64'd0);
    endtask

    initial begin
        //            pop   data          last  done  pass  seg   err
        vecs[0]  = '{1'b0, 32'h5000_0008, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[1]  = '{1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[2]  = '{1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
        vecs[3]  = '{1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 32'hE000_0000, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0};
        vecs[6]  = '{1'b0, 32'h4000_0005, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
        vecs[7]  = '{1'b0, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
        vecs[8]  = '{1'b0, 32'hBBBB_00CC, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
        vecs[9]  = '{1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[10] = '{1'b1, 32'hBBBB_00CC, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[11] = '{1'b0, 32'hF000_0000, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0};
        vecs[12] = '{1'b0, 32'h5000_0000, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0};
        vecs[13] = '{1'b0, 32'hE000_0000, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0};
        vecs[14] = '{1'b0, 32'h1234_0004, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0};
        vecs[15] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0};
        vecs[16] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};

        #2 rst = 1'b0;
        #10;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", 64'(do_ready), 64'd1);

        run_vecs(0, 13);
        chk("zero_len_fifo_empty", 64'(out_valid), 64'd0);
        run_vecs(14, 16);

        // Backpressure: 20-word segment into a 16-entry FIFO with the host stalled.
        send(32'h5000_0050, 1'b0);
        chk("bp_hdr_seg", 64'(seg_cnt), 64'd5);
        for (int i = 0; i < 16; i++) begin
            send(32'h3000_0000 + 32'(i), 1'b0);
        end
        @(negedge clk);
        chk("bp_ready_low_when_full", 64'(do_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        fork
            begin
                for (int i = 16; i < 20; i++) begin
                    send(32'h3000_0000 + 32'(i), 1'b0);
                end
            end
            begin
                for (int j = 0; j < 20; j++) begin
                    pop_check($sformatf("bp_pop%0d", j), 32'h3000_0000 + 32'(j), (j == 19));
                end
            end
        join
        @(negedge clk);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Early do_last inside a segment, then status without do_last, then clear.
        send(32'h5000_0010, 1'b0);
        send(32'h0000_0001, 1'b0);
        chk("err_before", 64'(proto_err), 64'd0);
        send(32'h0000_0002, 1'b1);
        chk("err_data_last", 64'(proto_err), 64'd1);
        pop_check("err_pop0", 32'h0000_0001, 1'b0);
        pop_check("err_pop1", 32'h0000_0002, 1'b0);
        send(32'hE000_0000, 1'b1);
        chk("err_back_in_hdr_done", 64'(done), 64'd1);
        chk("err_sticky", 64'(proto_err), 64'd1);
        chk("err_status_not_pushed", 64'(out_valid), 64'd0);
        do_clear();
        chk("clr_err", 64'(proto_err), 64'd0);
        chk("clr_seg", 64'(seg_cnt), 64'd0);
        chk("clr_pass", 64'(pass), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        send(32'hF000_0000, 1'b0);
        chk("stat_nolast_err", 64'(proto_err), 64'd1);
        chk("stat_nolast_done", 64'(done), 64'd1);
        chk("stat_nolast_pass", 64'(pass), 64'd0);
        do_clear();
        chk("clr2_err", 64'(proto_err), 64'd0);

        // Asynchronous reset in the middle of a data segment.
        send(32'h5000_0010, 1'b0);
        send(32'hCAFE_F00D, 1'b0);
        #2;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        run_vecs(0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
